// File: rtl/bcd_dabble_seq_pkg.sv
// ============================================================================
// Module : bcd_dabble_seq_pkg
// Brief  : Shared FSM encoding, blank code and sizing helpers for the
//          iterative double-dabble binary-to-BCD converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_dabble_seq_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Decimal digits of 2^width-1 = floor(width*log10(2)) + 1
    function automatic int nfull_digits(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

    function automatic int iter_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_seq_if.sv
// ============================================================================
// Module : bcd_dabble_seq_if
// Brief  : Start/done handshake and result bus of the BCD converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_dabble_seq_if #(
    parameter int WIDTH  = 36,
    parameter int DIGITS = 11
);
    logic                  start;
    logic [WIDTH-1:0]      data;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, data,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, data,
        output busy, done, bcd_out, overflow
    );
endinterface

`default_nettype wire

// File: rtl/bcd_add3_digit.sv
// ============================================================================
// Module : bcd_add3_digit
// Brief  : Combinational double-dabble digit correction (>=5 gets +3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_add3_digit (
    input  wire logic [3:0] i_digit,
    output logic      [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
endmodule

`default_nettype wire

// File: rtl/bcd_dabble_seq.sv
// ============================================================================
// Module : bcd_dabble_seq
// Brief  : Iterative shift-add-3 binary-to-BCD converter, one bit per cycle,
//          registered digits held between conversions.
//          Optional macro BCD_DABBLE_LEADING_BLANK_EN blanks leading zeros.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_dabble_seq
    import bcd_dabble_seq_pkg::*;
#(
    parameter int WIDTH  = 36,
    parameter int DIGITS = 11
) (
    input  wire logic        Clk,
    input  wire logic        reset_n,
    bcd_dabble_seq_if.slave  bus
);
    localparam int NFULL = nfull_digits(WIDTH);
    localparam int CW    = iter_width(WIDTH);
    localparam int TOT   = 4 * NFULL + WIDTH;

    logic [1:0]            r_state;
    logic [WIDTH-1:0]      r_shift;
    logic [4*NFULL-1:0]    r_scratch;
    logic [CW-1:0]         r_iter;
    logic                  r_done;
    logic                  r_ovf;
    logic [4*DIGITS-1:0]   r_bcd;

    logic [4*NFULL-1:0]    w_adj;
    logic [TOT-1:0]        w_cat;
    logic [4*DIGITS-1:0]   w_low;
    logic [4*DIGITS-1:0]   w_bcd;
    logic                  w_ovf;

    generate
        for (genvar g = 0; g < NFULL; g++) begin : g_add3
            bcd_add3_digit u_add3 (
                .i_digit (r_scratch[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end

        for (genvar g = 0; g < DIGITS; g++) begin : g_low
            if (g < NFULL) begin : g_src
                assign w_low[4*g +: 4] = r_scratch[4*g +: 4];
            end else begin : g_pad
                assign w_low[4*g +: 4] = 4'd0;
            end
        end

        if (DIGITS < NFULL) begin : g_ovf
            assign w_ovf = |r_scratch[4*NFULL-1:4*DIGITS];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    assign w_cat = {w_adj, r_shift} << 1;

`ifdef BCD_DABBLE_LEADING_BLANK_EN
    logic w_lead;

    // Blank zeros from the top down until the first non-zero digit; digit 0 stays
    always_comb begin
        w_bcd  = w_low;
        w_lead = 1'b1;
        if (!w_ovf) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (w_low[4*i +: 4] != 4'd0) begin
                    w_lead = 1'b0;
                end
                if (w_lead) begin
                    w_bcd[4*i +: 4] = BLANK_CODE;
                end
            end
        end
    end
`else
    assign w_bcd = w_low;
`endif

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_iter    <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_shift   <= bus.data;
                        r_scratch <= '0;
                        r_iter    <= CW'(WIDTH);
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_cat[TOT-1:WIDTH];
                    r_shift   <= w_cat[WIDTH-1:0];
                    r_iter    <= r_iter - CW'(1);
                    if (r_iter == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bcd   <= w_bcd;
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.bcd_out  = r_bcd;
    assign bus.overflow = r_ovf;

endmodule

`default_nettype wire

// File: doc/bcd_dabble_seq.md
Name: bcd_dabble_seq

Overview:
Iterative shift-add-3 (double-dabble) binary-to-BCD converter with a start/done handshake. Sits between the free-running event counter and the 3-digit frame display sequencer. Latches a snapshot of the counter, converts it over WIDTH cycles, and presents stable registered BCD digits to the display. Replaces the combinational converter to cut logic depth at 50 MHz.

Parameters:
WIDTH, 36, binary input width (>=4).
DIGITS, 11, number of BCD digits presented on bcd_out (>=1).

Ports:
Clk  input  1  system clock (CLOCK_50 domain)
reset_n  input  1  asynchronous active-low reset
start  input  1  request conversion of data; sampled only in IDLE
data  input  WIDTH  unsigned binary value, captured on the accepted start edge
busy  output  1  high while a conversion is in flight (state != IDLE)
done  output  1  one-cycle pulse; bcd_out/overflow valid and updated on the same edge
bcd_out  output  4*DIGITS  BCD digits, digit 0 in [3:0]; held between conversions
overflow  output  1  value did not fit in DIGITS digits; updated with done

Behaviour:
- Reset (async, reset_n low): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, internal shift/scratch/counter=0. Reset mid-conversion aborts it; no done is produced.
- Internal scratch holds NFULL digits, NFULL = digits needed for 2^WIDTH-1 (11 for WIDTH=36), computed in the package.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on start=1, load shift reg <- data, scratch <- 0, iter <- WIDTH, go to SHIFT. start=0: stay; done=0.
- SHIFT: each cycle, add 3 to every scratch digit >=5, then shift {scratch, shiftreg} left one bit; decrement iter. After the WIDTH-th shift go to DONE.
- DONE: for one cycle, bcd_out <= low DIGITS digits of scratch; overflow <= OR of digits DIGITS..NFULL-1 (0 when DIGITS >= NFULL); done <= 1 on this edge; state -> IDLE.
- Timing: start accepted at edge 0; shifts on edges 1..WIDTH; bcd_out/done/overflow update on edge WIDTH+1. done is high exactly one cycle. busy is high from edge 0 through edge WIDTH+1, which is WIDTH+1 cycles.
- start while busy=1 is ignored and is not queued. data changes during a conversion have no effect.
- done cycle: state is already IDLE, so a start in that cycle is accepted. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- Overflow truncates: bcd_out keeps the low DIGITS digits of the correct decimal value.
- bcd_out and overflow are held unchanged between done pulses.

Optional Feature:
Macro BCD_DABBLE_LEADING_BLANK_EN.
- Defined: when bcd_out loads in DONE, each leading-zero digit above digit 0 is replaced by 4'hF, the display's blank code. Digit 0 is never blanked; value 0 gives F..F0. If overflow=1, no blanking is applied. Reset value remains all-zero.
- Undefined: plain BCD output with leading zeros.

Decomposition:
- Shared package: FSM state encoding (IDLE/SHIFT/DONE); BLANK_CODE = 4'hF; NFULL function/constant from WIDTH; iteration counter width clog2(WIDTH+1).
- One sub-module, bcd_add3_digit: combinational digit correction, >=5 gives +3. Instantiate NFULL times with a generate loop.

Test Plan:
- data=0, start pulse -> done after exactly 37 cycles (WIDTH=36), bcd_out=0, overflow=0. With BLANK_EN: bcd_out={10 x F, 0}.
- data=36'd12345 -> bcd_out digits 4..0 = 1,2,3,4,5, upper digits 0, done high for exactly one cycle, busy high 37 cycles.
- data=2^36-1 with DIGITS=11 -> bcd_out=68719476735, overflow=0. Same value with DIGITS=9 -> bcd_out=719476735, overflow=1.
- start with data=5, then start with data=9 at cycle 10 while busy -> single done, bcd_out=5. Next start issued in the done cycle with data=42 -> accepted, second done 37 cycles later with bcd_out=42.
- Mid-conversion reset_n low at cycle 20 -> all outputs 0 immediately, no done pulse. After release, start with data=100 -> bcd_out=100.
- Random 1000 values with random start gaps -> bcd_out matches reference decimal conversion; done count equals accepted starts.
